// File: rtl/sd_pkg.sv
// Shared types and constants for the SD block-read sequencer.
// The state encoding, token byte values and the default block length live here.
package sd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_TOK,
      ST_DATA,
      ST_CRC,
      ST_FIN
   } state_t;

   localparam logic [7:0] TOK_START   = 8'hFE;
   localparam logic [7:0] TOK_IDLE    = 8'hFF;
   localparam int         BLK_LEN_DEF = 512;

endpackage

// File: rtl/sd_rr_arb2.sv
// Two-way round-robin arbiter.
// The winner is combinational; load commits it as the last-served requester.
module sd_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       load,
   output logic [1:0] win,
   output logic       last
);

   logic last_q, last_d;

   always_comb begin
      win = 2'b00;
      case (req)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         // On a tie, serve whoever was not served last.
         2'b11:   win = last_q ? 2'b01 : 2'b10;
         default: win = 2'b00;
      endcase
   end

   always_comb begin
      last_d = last_q;
      if (load && (win != 2'b00))
         last_d = win[1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_q <= 1'b1;
      else
         last_q <= last_d;
   end

   assign last = last_q;

endmodule

// File: rtl/sd_rd_sched.sv
// Block-read sequencer sharing the SPI byte engine between two DMA requesters:
// arbitrate, hunt for the start token, stream BLK_LEN bytes, capture the CRC.
module sd_rd_sched
   import sd_pkg::*;
#(
   parameter int TOK_TIMEOUT = 1024,
   parameter int BLK_LEN     = BLK_LEN_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   output logic [1:0]  grant,
   output logic [7:0]  rd_data,
   output logic        rd_stb,
   output logic        rd_last,
   output logic [15:0] rd_crc,
   output logic        done,
   output logic        err,
   output logic        spi_start,
   output logic [7:0]  spi_dout,
   input  logic        spi_done,
   input  logic [7:0]  spi_din
);

   localparam int BW = $clog2(BLK_LEN) + 1;
   localparam int HW = $clog2(TOK_TIMEOUT) + 1;

   state_t        state_q, state_d;
   logic [1:0]    grant_q, grant_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          rd_stb_q, rd_stb_d;
   logic          rd_last_q, rd_last_d;
   logic [15:0]   rd_crc_q, rd_crc_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          fail_q, fail_d;
   logic          spi_start_q, spi_start_d;
   logic          out_q, out_d;
   logic [BW-1:0] byte_cnt_q, byte_cnt_d;
   logic [HW-1:0] hunt_cnt_q, hunt_cnt_d;

   logic [1:0]    arb_win;
   logic          arb_load;
   logic          arb_last;
   logic          xfer_state;

   sd_rr_arb2 u_arb (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .load (arb_load),
      .win  (arb_win),
      .last (arb_last)
   );

   assign xfer_state = (state_q == ST_TOK) || (state_q == ST_DATA) || (state_q == ST_CRC);

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rd_data_d   = rd_data_q;
      rd_stb_d    = 1'b0;
      rd_last_d   = 1'b0;
      rd_crc_d    = rd_crc_q;
      done_d      = 1'b0;
      err_d       = err_q;
      fail_d      = fail_q;
      spi_start_d = 1'b0;
      out_d       = out_q;
      byte_cnt_d  = byte_cnt_q;
      hunt_cnt_d  = hunt_cnt_q;
      arb_load    = 1'b0;

      if (spi_done)
         out_d = 1'b0;
      // Issuing off the registered flag guarantees a gap cycle after spi_done.
      if (xfer_state && !out_q) begin
         spi_start_d = 1'b1;
         out_d       = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (|req)
               state_d = ST_ARB;
         end
         ST_ARB: begin
            if (arb_win != 2'b00) begin
               grant_d    = arb_win;
               arb_load   = 1'b1;
               err_d      = 1'b0;
               fail_d     = 1'b0;
               hunt_cnt_d = '0;
               byte_cnt_d = '0;
               state_d    = ST_TOK;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_TOK: begin
            if (spi_done) begin
               if (spi_din == TOK_IDLE) begin
                  if (hunt_cnt_q + HW'(1) == HW'(TOK_TIMEOUT)) begin
                     fail_d  = 1'b1;
                     state_d = ST_FIN;
                  end else begin
                     hunt_cnt_d = hunt_cnt_q + HW'(1);
                  end
               end else if (spi_din == TOK_START) begin
                  byte_cnt_d = '0;
                  state_d    = ST_DATA;
               end else begin
                  fail_d  = 1'b1;
                  state_d = ST_FIN;
               end
            end
         end
         ST_DATA: begin
            if (spi_done) begin
               rd_data_d  = spi_din;
               rd_stb_d   = 1'b1;
               byte_cnt_d = byte_cnt_q + BW'(1);
               if (byte_cnt_q == BW'(BLK_LEN - 1)) begin
                  rd_last_d  = 1'b1;
                  byte_cnt_d = '0;
                  state_d    = ST_CRC;
               end
            end
         end
         ST_CRC: begin
            // byte_cnt_q is reused to tell the two CRC bytes apart.
            if (spi_done) begin
               if (byte_cnt_q == '0) begin
                  rd_crc_d   = {spi_din, rd_crc_q[7:0]};
                  byte_cnt_d = BW'(1);
               end else begin
                  rd_crc_d = {rd_crc_q[15:8], spi_din};
                  state_d  = ST_FIN;
               end
            end
         end
         ST_FIN: begin
            done_d  = 1'b1;
            err_d   = fail_q;
            grant_d = 2'b00;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         grant_q     <= 2'b00;
         rd_data_q   <= 8'h00;
         rd_stb_q    <= 1'b0;
         rd_last_q   <= 1'b0;
         rd_crc_q    <= 16'h0000;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         fail_q      <= 1'b0;
         spi_start_q <= 1'b0;
         out_q       <= 1'b0;
         byte_cnt_q  <= '0;
         hunt_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rd_data_q   <= rd_data_d;
         rd_stb_q    <= rd_stb_d;
         rd_last_q   <= rd_last_d;
         rd_crc_q    <= rd_crc_d;
         done_q      <= done_d;
         err_q       <= err_d;
         fail_q      <= fail_d;
         spi_start_q <= spi_start_d;
         out_q       <= out_d;
         byte_cnt_q  <= byte_cnt_d;
         hunt_cnt_q  <= hunt_cnt_d;
      end
   end

   assign grant     = grant_q;
   assign rd_data   = rd_data_q;
   assign rd_stb    = rd_stb_q;
   assign rd_last   = rd_last_q;
   assign rd_crc    = rd_crc_q;
   assign done      = done_q;
   assign err       = err_q;
   assign spi_start = spi_start_q;
   assign spi_dout  = TOK_IDLE;

endmodule

// File: tb/tb_sd_rd_sched.sv
// Directed bench for sd_rd_sched with a scripted SPI byte-engine model.
// Expected values are hand-derived from the block protocol and timing.
module tb_sd_rd_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  grant;
   logic [7:0]  rd_data;
   logic        rd_stb;
   logic        rd_last;
   logic [15:0] rd_crc;
   logic        done;
   logic        err;
   logic        spi_start;
   logic [7:0]  spi_dout;
   logic        spi_done = 1'b0;
   logic [7:0]  spi_din  = 8'h00;

   int vectors     = 0;
   int miscompares = 0;

   sd_rd_sched #(.TOK_TIMEOUT(16), .BLK_LEN(512)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .grant     (grant),
      .rd_data   (rd_data),
      .rd_stb    (rd_stb),
      .rd_last   (rd_last),
      .rd_crc    (rd_crc),
      .done      (done),
      .err       (err),
      .spi_start (spi_start),
      .spi_dout  (spi_dout),
      .spi_done  (spi_done),
      .spi_din   (spi_din)
   );

   always #5 clk = ~clk;

   // Card script: m_nff idle bytes, token, 512 counting bytes, two CRC bytes.
   int          m_nff = 0;
   logic [7:0]  m_tok = 8'hFE;
   logic [15:0] m_crc = 16'h0000;

   function automatic logic [7:0] resp(input int k);
      int d;
      if (k < m_nff) return 8'hFF;
      if (k == m_nff) return m_tok;
      d = k - m_nff - 1;
      if (d < 512) return d[7:0];
      if (d == 512) return m_crc[15:8];
      if (d == 513) return m_crc[7:0];
      return 8'hFF;
   endfunction

   int eng_idx  = 0;
   int eng_dly  = 0;
   bit eng_busy = 1'b0;

   always @(posedge clk) begin
      spi_done <= 1'b0;
      if (rst || done) begin
         eng_idx  <= 0;
         eng_busy <= 1'b0;
      end else if (eng_busy) begin
         if (eng_dly == 0) begin
            spi_done <= 1'b1;
            spi_din  <= resp(eng_idx);
            eng_idx  <= eng_idx + 1;
            eng_busy <= 1'b0;
         end else begin
            eng_dly <= eng_dly - 1;
         end
      end else if (spi_start) begin
         eng_busy <= 1'b1;
         eng_dly  <= 1;
      end
   end

   // Output monitor.
   int         blk_stb     = 0;
   int         stb_total   = 0;
   int         last_cnt    = 0;
   int         last_at     = -1;
   int         data_bad    = 0;
   int         start_total = 0;
   logic [1:0] last_grant  = 2'b00;

   always @(negedge clk) begin
      if (rst) begin
         blk_stb <= 0;
      end else begin
         if (rd_stb) begin
            if (rd_data !== blk_stb[7:0]) data_bad <= data_bad + 1;
            if (rd_last) begin
               last_cnt <= last_cnt + 1;
               last_at  <= blk_stb;
            end
            blk_stb   <= blk_stb + 1;
            stb_total <= stb_total + 1;
         end
         if (done) blk_stb <= 0;
      end
      if (spi_start) start_total <= start_total + 1;
      if (grant != 2'b00) last_grant <= grant;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 12000; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
   endtask

   task automatic wait_stb(input string tag, input int n);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 12000; i++) begin
         @(negedge clk);
         if (blk_stb >= n) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, "_stb_reached"}, {31'd0, seen}, 32'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_grant"},     {30'd0, grant},     32'd0);
      chk({tag, "_rd_data"},   {24'd0, rd_data},   32'd0);
      chk({tag, "_rd_stb"},    {31'd0, rd_stb},    32'd0);
      chk({tag, "_rd_last"},   {31'd0, rd_last},   32'd0);
      chk({tag, "_rd_crc"},    {16'd0, rd_crc},    32'd0);
      chk({tag, "_done"},      {31'd0, done},      32'd0);
      chk({tag, "_err"},       {31'd0, err},       32'd0);
      chk({tag, "_spi_start"}, {31'd0, spi_start}, 32'd0);
      chk({tag, "_spi_dout"},  {24'd0, spi_dout},  32'hFF);
   endtask

   int s_stb, s_last, s_bad, s_start;

   task automatic snap();
      s_stb   = stb_total;
      s_last  = last_cnt;
      s_bad   = data_bad;
      s_start = start_total;
   endtask

   initial begin
      rst = 1'b1;
      req = 2'b00;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // Single block from requester 0, with request-to-grant latency checks.
      m_nff = 3; m_tok = 8'hFE; m_crc = 16'hABCD;
      snap();
      req = 2'b01;
      @(negedge clk);
      chk("t1_grant_n", {30'd0, grant}, 32'd0);
      @(negedge clk);
      chk("t1_grant_n1", {30'd0, grant}, 32'h1);
      chk("t1_start_n1", {31'd0, spi_start}, 32'd0);
      @(negedge clk);
      chk("t1_start_n2", {31'd0, spi_start}, 32'd1);
      wait_done("t1");
      req = 2'b00;
      chk("t1_err", {31'd0, err}, 32'd0);
      chk("t1_grant_at_done", {30'd0, grant}, 32'd0);
      chk("t1_crc", {16'd0, rd_crc}, 32'hABCD);
      chk("t1_stb_count", stb_total - s_stb, 32'd512);
      chk("t1_last_count", last_cnt - s_last, 32'd1);
      chk("t1_last_pos", last_at, 32'd511);
      chk("t1_data_bad", data_bad - s_bad, 32'd0);
      chk("t1_starts", start_total - s_start, 32'd518);
      chk("t1_block_grant", {30'd0, last_grant}, 32'h1);
      @(negedge clk);
      chk("t1_done_one_cycle", {31'd0, done}, 32'd0);

      // Round-robin tie from a fresh pointer, with FIN-to-ARB turnaround.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      m_nff = 1; m_crc = 16'h0102;
      req = 2'b11;
      wait_done("t2a");
      chk("t2a_grant", {30'd0, last_grant}, 32'h1);
      @(negedge clk);
      chk("t2_turn_idle", {30'd0, grant}, 32'd0);
      @(negedge clk);
      chk("t2_turn_grant", {30'd0, grant}, 32'h2);
      wait_done("t2b");
      chk("t2b_grant", {30'd0, last_grant}, 32'h2);
      wait_done("t2c");
      req = 2'b00;
      chk("t2c_grant", {30'd0, last_grant}, 32'h1);
      chk("t2c_err", {31'd0, err}, 32'd0);

      // Error token after two idle bytes.
      m_nff = 2; m_tok = 8'h05;
      snap();
      req = 2'b01;
      wait_done("t3");
      req = 2'b00;
      chk("t3_err", {31'd0, err}, 32'd1);
      chk("t3_grant_at_done", {30'd0, grant}, 32'd0);
      chk("t3_stb_count", stb_total - s_stb, 32'd0);
      chk("t3_starts", start_total - s_start, 32'd3);
      @(negedge clk);
      chk("t3_err_holds", {31'd0, err}, 32'd1);
      chk("t3_done_low", {31'd0, done}, 32'd0);

      // Token-hunt timeout: only idle bytes from the card.
      m_nff = 100000; m_tok = 8'hFE;
      snap();
      req = 2'b10;
      wait_done("t4");
      req = 2'b00;
      chk("t4_err", {31'd0, err}, 32'd1);
      chk("t4_starts", start_total - s_start, 32'd16);
      chk("t4_stb_count", stb_total - s_stb, 32'd0);
      chk("t4_block_grant", {30'd0, last_grant}, 32'h2);

      // Request dropped mid-block: the block still drains fully.
      m_nff = 0; m_tok = 8'hFE; m_crc = 16'h1234;
      snap();
      req = 2'b01;
      wait_stb("t5", 100);
      req = 2'b00;
      wait_done("t5");
      chk("t5_err", {31'd0, err}, 32'd0);
      chk("t5_stb_count", stb_total - s_stb, 32'd512);
      chk("t5_last_count", last_cnt - s_last, 32'd1);
      chk("t5_crc", {16'd0, rd_crc}, 32'h1234);
      chk("t5_data_bad", data_bad - s_bad, 32'd0);

      // Reset mid-block, then a clean block.
      m_nff = 1; m_crc = 16'h5A5A;
      req = 2'b01;
      wait_stb("t6", 200);
      rst = 1'b1;
      #1;
      chk_reset_outputs("t6_rst");
      @(negedge clk);
      rst = 1'b0;
      snap();
      wait_done("t6");
      req = 2'b00;
      chk("t6_err", {31'd0, err}, 32'd0);
      chk("t6_stb_count", stb_total - s_stb, 32'd512);
      chk("t6_starts", start_total - s_start, 32'd516);
      chk("t6_crc", {16'd0, rd_crc}, 32'h5A5A);
      chk("t6_data_bad", data_bad - s_bad, 32'd0);
      chk("t6_last_pos", last_at, 32'd511);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
